// File: rtl/ddr_clock_generator.sv
// ddr_clock_generator
// Multi-channel complementary clock generator. Each channel divides Clock into
// a non-overlapping ClockP/ClockN pair with programmable high-phase length and
// dead time. Settings are staged in shadow registers and copied into each
// channel's active registers only when that channel enters HIGH_P, so a period
// never mixes old and new values. Stopping always completes the current period.
// The dead-time field is assumed to be no wider than the divide field, because
// both share the per-channel phase counter.
module ddr_clock_generator #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 8,
  parameter int DT_WIDTH  = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [CHANNELS-1:0]           Enable,
  input  logic [CHANNELS*DIV_WIDTH-1:0] Divide,
  input  logic [DT_WIDTH-1:0]           DeadTime,
  input  logic                          Load,
  output logic [CHANNELS-1:0]           ClockP,
  output logic [CHANNELS-1:0]           ClockN,
  output logic [CHANNELS-1:0]           Running
);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DT_WIDTH-1:0]  DT_ZERO  = {DT_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HIGH_P  = 3'd1,
    DEAD_PN = 3'd2,
    HIGH_N  = 3'd3,
    DEAD_NP = 3'd4
  } PhaseState;

  // A programmed high length of zero behaves as one cycle.
  function automatic logic [DIV_WIDTH-1:0] effectiveHigh(input logic [DIV_WIDTH-1:0] value);
    return (value == DIV_ZERO) ? DIV_ONE : value;
  endfunction

  // Counter reload for a dead phase of 'value' cycles (value is non-zero here).
  function automatic logic [DIV_WIDTH-1:0] deadReload(input logic [DT_WIDTH-1:0] value);
    return DIV_WIDTH'(value) - DIV_ONE;
  endfunction

  logic [CHANNELS*DIV_WIDTH-1:0] shadowDivide_r;
  logic [DT_WIDTH-1:0]           shadowDeadTime_r;

  // Shadow registers: capture the programming inputs on Load.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadowDivide_r   <= {CHANNELS{DIV_ONE}};
      shadowDeadTime_r <= DT_ZERO;
    end else if (Load) begin
      shadowDivide_r   <= Divide;
      shadowDeadTime_r <= DeadTime;
    end else begin
      shadowDivide_r   <= shadowDivide_r;
      shadowDeadTime_r <= shadowDeadTime_r;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : gChannel
    PhaseState            state_r;
    logic [DIV_WIDTH-1:0] count_r;
    logic [DIV_WIDTH-1:0] highLen_r;
    logic [DT_WIDTH-1:0]  deadLen_r;
    logic                 clockP_r;
    logic                 clockN_r;
    logic                 running_r;
    logic [DIV_WIDTH-1:0] nextHigh_s;

    assign nextHigh_s = effectiveHigh(shadowDivide_r[c*DIV_WIDTH +: DIV_WIDTH]);

    // Per-channel phase FSM; outputs are registered alongside the state so
    // they change on exactly the edge that enters each phase.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        state_r   <= IDLE;
        count_r   <= DIV_ZERO;
        highLen_r <= DIV_ONE;
        deadLen_r <= DT_ZERO;
        clockP_r  <= 1'b0;
        clockN_r  <= 1'b0;
        running_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (Enable[c]) begin
              state_r   <= HIGH_P;
              highLen_r <= nextHigh_s;
              deadLen_r <= shadowDeadTime_r;
              count_r   <= nextHigh_s - DIV_ONE;
              clockP_r  <= 1'b1;
              running_r <= 1'b1;
            end else begin
              clockP_r  <= 1'b0;
              running_r <= 1'b0;
            end
            clockN_r <= 1'b0;
          end
          HIGH_P: begin
            if (count_r != DIV_ZERO) begin
              count_r <= count_r - DIV_ONE;
            end else if (deadLen_r != DT_ZERO) begin
              state_r  <= DEAD_PN;
              count_r  <= deadReload(deadLen_r);
              clockP_r <= 1'b0;
            end else begin
              state_r  <= HIGH_N;
              count_r  <= highLen_r - DIV_ONE;
              clockP_r <= 1'b0;
              clockN_r <= 1'b1;
            end
          end
          DEAD_PN: begin
            if (count_r != DIV_ZERO) begin
              count_r <= count_r - DIV_ONE;
            end else begin
              state_r  <= HIGH_N;
              count_r  <= highLen_r - DIV_ONE;
              clockN_r <= 1'b1;
            end
          end
          HIGH_N, DEAD_NP: begin
            // Both phases end a period when no dead phase follows; only the
            // period end samples Enable, so a stop never truncates a pulse.
            if (count_r != DIV_ZERO) begin
              count_r <= count_r - DIV_ONE;
            end else if ((state_r == HIGH_N) && (deadLen_r != DT_ZERO)) begin
              state_r  <= DEAD_NP;
              count_r  <= deadReload(deadLen_r);
              clockN_r <= 1'b0;
            end else if (Enable[c]) begin
              state_r   <= HIGH_P;
              highLen_r <= nextHigh_s;
              deadLen_r <= shadowDeadTime_r;
              count_r   <= nextHigh_s - DIV_ONE;
              clockP_r  <= 1'b1;
              clockN_r  <= 1'b0;
            end else begin
              state_r   <= IDLE;
              count_r   <= DIV_ZERO;
              clockN_r  <= 1'b0;
              running_r <= 1'b0;
            end
          end
          default: begin
            state_r   <= IDLE;
            count_r   <= DIV_ZERO;
            clockP_r  <= 1'b0;
            clockN_r  <= 1'b0;
            running_r <= 1'b0;
          end
        endcase
      end
    end

    assign ClockP[c]  = clockP_r;
    assign ClockN[c]  = clockN_r;
    assign Running[c] = running_r;
  end

endmodule

// File: tb/tb_ddr_clock_generator.sv
// Directed self-checking bench for ddr_clock_generator (4 channels, 8-bit
// divide, 4-bit dead time). Inputs change and outputs are sampled on the
// falling edge of Clock.
module tb_ddr_clock_generator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Enable = 4'b0000;
  logic [31:0] Divide = 32'h0000_0000;
  logic [3:0]  DeadTime = 4'd0;
  logic        Load = 1'b0;
  logic [3:0]  ClockP;
  logic [3:0]  ClockN;
  logic [3:0]  Running;

  int passCount = 0;
  int checkCount = 0;
  int overlapCount = 0;

  always #5 Clock = ~Clock;

  ddr_clock_generator #(.CHANNELS(4), .DIV_WIDTH(8), .DT_WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Divide(Divide),
    .DeadTime(DeadTime), .Load(Load), .ClockP(ClockP), .ClockN(ClockN),
    .Running(Running)
  );

  // Count any cycle where a channel drives P and N together.
  always @(negedge Clock) begin
    if (!Reset && ((ClockP & ClockN) != 4'b0000)) overlapCount++;
  end

  assert property (@(posedge Clock) disable iff (Reset) (ClockP & ClockN) == 4'b0000)
    else $error("FAIL overlap_assert P=%b N=%b", ClockP, ClockN);

  // Reference waveform: P high for phase [0,h), N high for [h+d, 2h+d).
  function automatic logic mP(input int h, input int d, input int i);
    int ph;
    ph = i % (2*h + 2*d);
    return (ph < h);
  endfunction

  function automatic logic mN(input int h, input int d, input int i);
    int ph;
    ph = i % (2*h + 2*d);
    return (ph >= h + d) && (ph < 2*h + d);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic loadShadow(input logic [31:0] div, input logic [3:0] dt);
    Divide = div; DeadTime = dt; Load = 1'b1;
    tick(1);
    Load = 1'b0;
  endtask

  task automatic waitIdle(input int ch, input int bound);
    for (int k = 0; k < bound && Running[ch] !== 1'b0; k++) tick(1);
    checkCount++;
    if (Running[ch] !== 1'b0) $display("FAIL idle_timeout_ch%0d got %b want 0", ch, Running[ch]);
    else passCount++;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Enable = 4'b1111;
    tick(2);
    checkCount++; if (ClockP !== 4'b0000) $display("FAIL reset_p got %b want 0000", ClockP); else passCount++;
    checkCount++; if (ClockN !== 4'b0000) $display("FAIL reset_n got %b want 0000", ClockN); else passCount++;
    checkCount++; if (Running !== 4'b0000) $display("FAIL reset_running got %b want 0000", Running); else passCount++;
    Reset = 1'b0; Enable = 4'b0000;
    tick(1);
    checkCount++; if (Running !== 4'b0000) $display("FAIL post_reset_idle got %b want 0000", Running); else passCount++;
  endtask

  task automatic test_basic_period;
    logic [19:0] pv, nv, rv, ep, en;
    loadShadow(32'h0000_0003, 4'd2);
    Enable[0] = 1'b1;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      pv[i] = ClockP[0]; nv[i] = ClockN[0]; rv[i] = Running[0];
      ep[i] = mP(3, 2, i); en[i] = mN(3, 2, i);
      tick(1);
    end
    checkCount++; if (pv !== ep) $display("FAIL basic_p got %b want %b", pv, ep); else passCount++;
    checkCount++; if (nv !== en) $display("FAIL basic_n got %b want %b", nv, en); else passCount++;
    checkCount++; if (rv !== 20'hFFFFF) $display("FAIL basic_running got %b want all ones", rv); else passCount++;
    Enable[0] = 1'b0;
    waitIdle(0, 50);
  endtask

  task automatic test_zero_dt_div;
    logic [7:0] pv, nv;
    loadShadow(32'h0000_0000, 4'd0);
    Enable[1] = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      pv[i] = ClockP[1]; nv[i] = ClockN[1];
      tick(1);
    end
    checkCount++; if (pv !== 8'b0101_0101) $display("FAIL zero_p got %b want 01010101", pv); else passCount++;
    checkCount++; if (nv !== 8'b1010_1010) $display("FAIL zero_n got %b want 10101010", nv); else passCount++;
    Enable[1] = 1'b0;
    waitIdle(1, 20);
  endtask

  task automatic test_mid_stop;
    logic [13:0] pv, nv, rv, ep, en, er;
    loadShadow(32'h0000_0004, 4'd1);
    Enable[0] = 1'b1;
    tick(1);
    for (int i = 0; i < 14; i++) begin
      pv[i] = ClockP[0]; nv[i] = ClockN[0]; rv[i] = Running[0];
      ep[i] = (i < 10) ? mP(4, 1, i) : 1'b0;
      en[i] = (i < 10) ? mN(4, 1, i) : 1'b0;
      er[i] = (i < 10);
      if (i == 1) Enable[0] = 1'b0;
      tick(1);
    end
    checkCount++; if (pv !== ep) $display("FAIL stop_p got %b want %b", pv, ep); else passCount++;
    checkCount++; if (nv !== en) $display("FAIL stop_n got %b want %b", nv, en); else passCount++;
    checkCount++; if (rv !== er) $display("FAIL stop_running got %b want %b", rv, er); else passCount++;
  endtask

  task automatic test_shadow_update;
    logic [29:0] pv, nv, ep, en;
    loadShadow(32'h0002_0000, 4'd1);
    Enable[2] = 1'b1;
    tick(1);
    for (int i = 0; i < 30; i++) begin
      pv[i] = ClockP[2]; nv[i] = ClockN[2];
      if (i < 6)       begin ep[i] = mP(2, 1, i);      en[i] = mN(2, 1, i);      end
      else if (i < 18) begin ep[i] = mP(5, 1, i - 6);  en[i] = mN(5, 1, i - 6);  end
      else             begin ep[i] = mP(3, 1, i - 18); en[i] = mN(3, 1, i - 18); end
      // Load H=5 during HIGH_N, then H=3 on the edge that starts period two.
      if (i == 3)      begin Divide = 32'h0005_0000; DeadTime = 4'd1; Load = 1'b1; end
      else if (i == 5) begin Divide = 32'h0003_0000; DeadTime = 4'd1; Load = 1'b1; end
      else             Load = 1'b0;
      tick(1);
    end
    Load = 1'b0;
    checkCount++; if (pv !== ep) $display("FAIL shadow_p got %b want %b", pv, ep); else passCount++;
    checkCount++; if (nv !== en) $display("FAIL shadow_n got %b want %b", nv, en); else passCount++;
    Enable[2] = 1'b0;
    waitIdle(2, 50);
  endtask

  task automatic test_reset_mid;
    logic [7:0] pv, nv;
    loadShadow(32'h0303_0303, 4'd2);
    Enable = 4'b1111;
    tick(7);
    checkCount++; if (ClockN !== 4'b1111) $display("FAIL pre_reset_n got %b want 1111", ClockN); else passCount++;
    Reset = 1'b1; Load = 1'b1; Divide = 32'h0707_0707; DeadTime = 4'd5;
    tick(1);
    checkCount++; if (ClockP !== 4'b0000) $display("FAIL midreset_p got %b want 0000", ClockP); else passCount++;
    checkCount++; if (ClockN !== 4'b0000) $display("FAIL midreset_n got %b want 0000", ClockN); else passCount++;
    checkCount++; if (Running !== 4'b0000) $display("FAIL midreset_running got %b want 0000", Running); else passCount++;
    Reset = 1'b0; Load = 1'b0; Enable = 4'b0000;
    tick(2);
    Enable[3] = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      pv[i] = ClockP[3]; nv[i] = ClockN[3];
      tick(1);
    end
    checkCount++; if (pv !== 8'b0101_0101) $display("FAIL shadow_reset_p got %b want 01010101", pv); else passCount++;
    checkCount++; if (nv !== 8'b1010_1010) $display("FAIL shadow_reset_n got %b want 10101010", nv); else passCount++;
    Enable[3] = 1'b0;
    waitIdle(3, 20);
  endtask

  task automatic test_multi_channel;
    int hv[4] = '{1, 2, 7, 255};
    int lastRise[4] = '{-1, -1, -1, -1};
    int firstRise[4] = '{-1, -1, -1, -1};
    int rises[4] = '{0, 0, 0, 0};
    int width[4] = '{0, 0, 0, 0};
    int badPeriod[4] = '{0, 0, 0, 0};
    int badWidth[4] = '{0, 0, 0, 0};
    logic [3:0] prevP = 4'b0000;
    loadShadow(32'hFF07_0201, 4'd3);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 0)  Enable[3] = 1'b1;
      if (cyc == 3)  Enable[2] = 1'b1;
      if (cyc == 5)  Enable[1] = 1'b1;
      if (cyc == 11) Enable[0] = 1'b1;
      tick(1);
      for (int c = 0; c < 4; c++) begin
        if (ClockP[c] && !prevP[c]) begin
          if (lastRise[c] >= 0 && (cyc - lastRise[c]) != 2*hv[c] + 6) badPeriod[c]++;
          if (firstRise[c] < 0) firstRise[c] = cyc;
          lastRise[c] = cyc;
          rises[c]++;
        end
        if (ClockP[c]) width[c]++;
        else if (prevP[c]) begin
          if (width[c] != hv[c]) badWidth[c]++;
          width[c] = 0;
        end
      end
      prevP = ClockP;
    end
    checkCount++; if (firstRise[3] !== 0) $display("FAIL start_latency_ch3 got %0d want 0", firstRise[3]); else passCount++;
    checkCount++; if (firstRise[0] !== 11) $display("FAIL start_latency_ch0 got %0d want 11", firstRise[0]); else passCount++;
    for (int c = 0; c < 4; c++) begin
      checkCount++;
      if (rises[c] < 2 || badPeriod[c] != 0)
        $display("FAIL period_ch%0d got %0d bad of %0d rises want 0 bad", c, badPeriod[c], rises[c]);
      else passCount++;
      checkCount++;
      if (badWidth[c] != 0) $display("FAIL pwidth_ch%0d got %0d bad want 0", c, badWidth[c]);
      else passCount++;
    end
    Enable = 4'b0000;
    for (int c = 0; c < 4; c++) waitIdle(c, 600);
    checkCount++; if (overlapCount != 0) $display("FAIL overlap_count got %0d want 0", overlapCount); else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_zero_dt_div();
    test_mid_stop();
    test_shadow_update();
    test_reset_mid();
    test_multi_channel();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
